// File: rtl/wash_duty_sequencer.sv
// wash_duty_sequencer
// Timed wash-cycle controller. It produces the 2-bit motor duty code for the
// PWM stage, plus phase and remaining-seconds values for the display path.
// Sequence: IDLE -> WASH -> GAP1 -> RINSE -> GAP2 -> SPIN -> DONE -> IDLE.
// Duty increases are soft-started by one step every RAMP_CYCLES cycles.
// Duty decreases take effect on the next edge.
//
// Ports:
//   sysclk        system clock; all logic runs on its rising edge
//   i_rst         asynchronous active-high reset
//   i_start       raw start/pause button level (asynchronous)
//   i_stop        raw abort button level (asynchronous)
//   o_pwm_duty    duty code: 0 off, 1 low, 2 mid, 3 high
//   o_phase       0 IDLE, 1 WASH, 2 GAP1, 3 RINSE, 4 GAP2, 5 SPIN, 6 DONE
//   o_remain_sec  ticks left in the current phase
//   o_paused      sequence is paused
//   o_busy        phase is one of 1..5
//   o_done        one-cycle pulse on entry to DONE
module wash_duty_sequencer #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned RAMP_CYCLES = 50_000_000,
    parameter int unsigned WASH_SEC    = 10,
    parameter int unsigned RINSE_SEC   = 8,
    parameter int unsigned SPIN_SEC    = 6,
    parameter int unsigned GAP_SEC     = 2
) (
    input  logic       sysclk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    output logic [1:0] o_pwm_duty,
    output logic [2:0] o_phase,
    output logic [7:0] o_remain_sec,
    output logic       o_paused,
    output logic       o_busy,
    output logic       o_done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_GAP1  = 3'd2,
        PH_RINSE = 3'd3,
        PH_GAP2  = 3'd4,
        PH_SPIN  = 3'd5,
        PH_DONE  = 3'd6
    } phase_t;

    // Button synchronizers and edge-detect history
    logic start_meta_q, start_sync_q, start_prev_q;
    logic stop_meta_q,  stop_sync_q,  stop_prev_q;
    logic start_evt, stop_evt;

    phase_t            phase_q,  phase_d;
    logic [7:0]        remain_q, remain_d;
    logic              paused_q, paused_d;
    logic [TICK_W-1:0] tick_q,   tick_d;
    logic [1:0]        duty_q,   duty_d;
    logic [RAMP_W-1:0] ramp_q,   ramp_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [1:0]        target;

    assign start_evt = start_sync_q & ~start_prev_q;
    assign stop_evt  = stop_sync_q  & ~stop_prev_q;

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            stop_meta_q  <= 1'b0;
            stop_sync_q  <= 1'b0;
            stop_prev_q  <= 1'b0;
            phase_q      <= PH_IDLE;
            remain_q     <= 8'd0;
            paused_q     <= 1'b0;
            tick_q       <= '0;
            duty_q       <= 2'd0;
            ramp_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            start_meta_q <= i_start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            stop_meta_q  <= i_stop;
            stop_sync_q  <= stop_meta_q;
            stop_prev_q  <= stop_sync_q;
            phase_q      <= phase_d;
            remain_q     <= remain_d;
            paused_q     <= paused_d;
            tick_q       <= tick_d;
            duty_q       <= duty_d;
            ramp_q       <= ramp_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Phase sequencing and tick counting
    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        paused_d = paused_q;
        tick_d   = tick_q;

        if (stop_evt) begin
            // Abort wins over a simultaneous start; in IDLE this is a no-op.
            phase_d  = PH_IDLE;
            remain_d = 8'd0;
            paused_d = 1'b0;
            tick_d   = '0;
        end else if (start_evt && phase_q == PH_IDLE) begin
            phase_d  = PH_WASH;
            remain_d = 8'(WASH_SEC);
            tick_d   = '0;
        end else begin
            if (start_evt && phase_q != PH_DONE) begin
                paused_d = ~paused_q;
            end
            // The counter keeps running on the edge that pauses and
            // freezes from the following cycle.
            if (phase_q != PH_IDLE && !paused_q) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (remain_q == 8'd1) begin
                        case (phase_q)
                            PH_WASH:  begin phase_d = PH_GAP1;  remain_d = 8'(GAP_SEC);   end
                            PH_GAP1:  begin phase_d = PH_RINSE; remain_d = 8'(RINSE_SEC); end
                            PH_RINSE: begin phase_d = PH_GAP2;  remain_d = 8'(GAP_SEC);   end
                            PH_GAP2:  begin phase_d = PH_SPIN;  remain_d = 8'(SPIN_SEC);  end
                            PH_SPIN:  begin phase_d = PH_DONE;  remain_d = 8'd1;          end
                            default:  begin phase_d = PH_IDLE;  remain_d = 8'd0;          end
                        endcase
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end

        busy_d = (phase_d != PH_IDLE) && (phase_d != PH_DONE);
        done_d = (phase_d == PH_DONE) && (phase_q != PH_DONE);
    end

    // Duty target and soft-start ramp
    always_comb begin
        target = 2'd0;
        if (!paused_q) begin
            case (phase_q)
                PH_WASH:  target = 2'd1;
                PH_RINSE: target = 2'd2;
                PH_SPIN:  target = 2'd3;
                default:  target = 2'd0;
            endcase
        end

        duty_d = duty_q;
        ramp_d = ramp_q;
        if (stop_evt) begin
            duty_d = 2'd0;
            ramp_d = '0;
        end else if (target > duty_q) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                duty_d = duty_q + 2'd1;
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end else begin
            // Step-downs are immediate; a ramp in progress is discarded.
            ramp_d = '0;
            duty_d = target;
        end
    end

    assign o_pwm_duty   = duty_q;
    assign o_phase      = phase_q;
    assign o_remain_sec = remain_q;
    assign o_paused     = paused_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
